// File: rtl/siren_sequencer_if.sv
// siren_sequencer_if: level inputs from the alarm controller and the
// registered siren/heartbeat/debug outputs of the siren sequencer.
// The master side is the alarm controller (or a bench); the slave side is
// the sequencer itself.
interface siren_sequencer_if;
    logic       set_in;     // armed level
    logic       alarm_in;   // siren-active level
    logic [2:0] siren;      // RGB drive {R,G,B}
    logic       armed_led;  // heartbeat LED
    logic [1:0] state_o;    // current state for display/debug

    modport master (
        output set_in,
        output alarm_in,
        input  siren,
        input  armed_led,
        input  state_o
    );

    modport slave (
        input  set_in,
        input  alarm_in,
        output siren,
        output armed_led,
        output state_o
    );
endinterface

// File: rtl/siren_sequencer.sv
// siren_sequencer: output stage of the alarm controller. Turns the steady
// armed/alarm levels into a timed RGB strobe, an arming chirp and an armed
// heartbeat, using an internal prescaler that produces one step pulse every
// DIV = CLK_HZ/STEP_HZ clocks.
// Optional feature macro SIREN_CHIRP_EN: when defined, arming passes through
// a CHIRP state that flashes white CHIRP_COUNT times; when undefined, arming
// goes straight to ARMED and CHIRP_COUNT has no effect.
module siren_sequencer #(
    parameter int CLK_HZ      = 100000000,
    parameter int STEP_HZ     = 4,
    parameter int CHIRP_COUNT = 2
) (
    input  logic             clock,
    input  logic             reset,
    siren_sequencer_if.slave bus
);
    localparam int DIV     = CLK_HZ / STEP_HZ;
    localparam int PRESC_W = $clog2(DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);

    // Bad configurations are rejected while elaborating rather than
    // producing a silently wrong pattern.
    if ((DIV < 2) || (CHIRP_COUNT < 1) || (CHIRP_COUNT > 7)) begin : g_bad_cfg
        $error("siren_sequencer: DIV must be >= 2 and CHIRP_COUNT within 1..7");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHIRP = 2'd1,
        ST_ARMED = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [2:0]           step_q, step_d;
    logic                 set_q;
    logic [2:0]           siren_q, siren_d;
    logic                 armed_led_q, armed_led_d;
    logic                 step_pulse;
    logic                 set_rise;
    logic                 state_change;
`ifdef SIREN_CHIRP_EN
    // Step pulses seen in CHIRP; the last one (2*CHIRP_COUNT-th) exits.
    localparam logic [3:0] CHIRP_LAST = 4'(2 * CHIRP_COUNT - 1);
    logic [3:0]           chirp_q, chirp_d;
`endif

    assign step_pulse   = (state_q != ST_IDLE) && (presc_q == PRESC_LAST);
    assign set_rise     = bus.set_in && !set_q;
    assign state_change = (state_d != state_q);

    // Next-state selection, highest priority first; an alarm always wins.
    always_comb begin
        state_d = state_q;
        if (bus.alarm_in) begin
            state_d = ST_ALARM;
        end else if (state_q == ST_ALARM) begin
            state_d = bus.set_in ? ST_ARMED : ST_IDLE;
        end else if (((state_q == ST_CHIRP) || (state_q == ST_ARMED)) && !bus.set_in) begin
            state_d = ST_IDLE;
        end else if ((state_q == ST_IDLE) && set_rise) begin
`ifdef SIREN_CHIRP_EN
            state_d = ST_CHIRP;
`else
            state_d = ST_ARMED;
`endif
        end
`ifdef SIREN_CHIRP_EN
        else if ((state_q == ST_CHIRP) && step_pulse && (chirp_q == CHIRP_LAST)) begin
            state_d = ST_ARMED;
        end
`endif
    end

    // Prescaler and step index restart on every state change so each
    // state's pattern begins from its first step.
    always_comb begin
        presc_d = presc_q;
        step_d  = step_q;
        if (state_change || (state_d == ST_IDLE)) begin
            presc_d = '0;
            step_d  = '0;
        end else begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
            if (step_pulse) begin
                step_d = step_q + 3'd1;
            end
        end
    end

`ifdef SIREN_CHIRP_EN
    // Chirp flash counter, only meaningful while in CHIRP.
    always_comb begin
        chirp_d = chirp_q;
        if (state_change) begin
            chirp_d = '0;
        end else if ((state_q == ST_CHIRP) && step_pulse) begin
            chirp_d = chirp_q + 4'd1;
        end
    end
`endif

    // Output decode from the next state/step so outputs move with the state.
    always_comb begin
        siren_d     = 3'b000;
        armed_led_d = 1'b0;
        case (state_d)
`ifdef SIREN_CHIRP_EN
            ST_CHIRP: siren_d = step_d[0] ? 3'b000 : 3'b111;
`endif
            ST_ARMED: armed_led_d = (step_d == 3'd0);
            ST_ALARM: begin
                case (step_d[1:0])
                    2'd0:    siren_d = 3'b100;
                    2'd2:    siren_d = 3'b001;
                    default: siren_d = 3'b000;
                endcase
            end
            default: ;
        endcase
    end

    // State, counters, edge register and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            step_q      <= '0;
            set_q       <= 1'b0;
            siren_q     <= 3'b000;
            armed_led_q <= 1'b0;
`ifdef SIREN_CHIRP_EN
            chirp_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            step_q      <= step_d;
            set_q       <= bus.set_in;
            siren_q     <= siren_d;
            armed_led_q <= armed_led_d;
`ifdef SIREN_CHIRP_EN
            chirp_q     <= chirp_d;
`endif
        end
    end

    assign bus.siren     = siren_q;
    assign bus.armed_led = armed_led_q;
    assign bus.state_o   = state_q;
endmodule

// File: tb/tb_siren_sequencer.sv
// tb_siren_sequencer: directed scenarios plus a randomized run for
// siren_sequencer with DIV = 8/2 = 4 and CHIRP_COUNT = 2. Works whether or
// not SIREN_CHIRP_EN is defined.
module tb_siren_sequencer;
    localparam int CLK_HZ      = 8;
    localparam int STEP_HZ     = 2;
    localparam int DIV         = CLK_HZ / STEP_HZ;
    localparam int CHIRP_COUNT = 2;
`ifdef SIREN_CHIRP_EN
    localparam int CHIRP_CYCLES = 2 * CHIRP_COUNT * DIV;
`else
    localparam int CHIRP_CYCLES = 0;
`endif

    logic clock = 1'b0;
    logic reset;

    siren_sequencer_if ifc ();

    siren_sequencer #(
        .CLK_HZ      (CLK_HZ),
        .STEP_HZ     (STEP_HZ),
        .CHIRP_COUNT (CHIRP_COUNT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc)
    );

    // Clock generation.
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: state plus cycles elapsed since entering it.
    int         m_state;
    int         m_k;
    bit         m_prev_set;
    logic [2:0] m_siren;
    logic       m_led;

    task automatic model_reset();
        m_state    = 0;
        m_k        = 0;
        m_prev_set = 1'b0;
        m_siren    = 3'b000;
        m_led      = 1'b0;
    endtask

    task automatic model_edge();
        int ns;
        int step;
        if (ifc.alarm_in) ns = 3;
        else if (m_state == 3) ns = ifc.set_in ? 2 : 0;
        else if ((m_state == 1 || m_state == 2) && !ifc.set_in) ns = 0;
        else if (m_state == 0 && ifc.set_in && !m_prev_set) ns = (CHIRP_CYCLES > 0) ? 1 : 2;
        else if (m_state == 1 && (m_k + 1) == CHIRP_CYCLES) ns = 2;
        else ns = m_state;
        if (ns != m_state) m_k = 0;
        else if (ns != 0) m_k = m_k + 1;
        m_prev_set = ifc.set_in;
        m_state    = ns;
        step       = (m_k / DIV) % 8;
        m_siren    = 3'b000;
        m_led      = 1'b0;
        case (m_state)
            1: m_siren = (step % 2 == 0) ? 3'b111 : 3'b000;
            2: m_led = (step == 0);
            3: m_siren = (step % 4 == 0) ? 3'b100 : ((step % 4 == 2) ? 3'b001 : 3'b000);
            default: ;
        endcase
    endtask

    // One clock: model follows the DUT edge, then wait for the sampling edge.
    task automatic advance();
        @(posedge clock);
        if (!reset) model_edge();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        ifc.set_in   = 1'b0;
        ifc.alarm_in = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        checks++;
        if ({ifc.siren, ifc.armed_led, ifc.state_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_hold: got siren=%b led=%b state=%0d, want all 0",
                     ifc.siren, ifc.armed_led, ifc.state_o);
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            advance();
            checks++;
            if ({ifc.siren, ifc.armed_led, ifc.state_o} !== 6'b0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: got siren=%b led=%b state=%0d, want all 0",
                         i, ifc.siren, ifc.armed_led, ifc.state_o);
            end
        end
    endtask

    task automatic test_arming();
        logic [2:0] exp_siren;
        ifc.set_in = 1'b1;
        for (int i = 0; i < CHIRP_CYCLES; i++) begin
            advance();
            exp_siren = (((i / DIV) % 2) == 0) ? 3'b111 : 3'b000;
            checks++;
            if (ifc.state_o !== 2'd1 || ifc.siren !== exp_siren || ifc.armed_led !== 1'b0) begin
                errors++;
                $display("FAIL chirp[%0d]: got state=%0d siren=%b led=%b, want state=1 siren=%b led=0",
                         i, ifc.state_o, ifc.siren, ifc.armed_led, exp_siren);
            end
        end
        for (int i = 0; i < 64; i++) begin
            advance();
            checks++;
            if (ifc.state_o !== 2'd2 || ifc.siren !== 3'b000 || ifc.armed_led !== ((i % 32) < DIV)) begin
                errors++;
                $display("FAIL armed[%0d]: got state=%0d siren=%b led=%b, want state=2 siren=000 led=%b",
                         i, ifc.state_o, ifc.siren, ifc.armed_led, ((i % 32) < DIV));
            end
        end
    endtask

    task automatic test_alarm_pattern();
        logic [2:0] exp_siren;
        ifc.alarm_in = 1'b1;
        for (int i = 0; i < 48; i++) begin
            advance();
            case ((i / DIV) % 4)
                0:       exp_siren = 3'b100;
                2:       exp_siren = 3'b001;
                default: exp_siren = 3'b000;
            endcase
            checks++;
            if (ifc.state_o !== 2'd3 || ifc.siren !== exp_siren || ifc.armed_led !== 1'b0) begin
                errors++;
                $display("FAIL alarm[%0d]: got state=%0d siren=%b led=%b, want state=3 siren=%b led=0",
                         i, ifc.state_o, ifc.siren, ifc.armed_led, exp_siren);
            end
        end
        ifc.alarm_in = 1'b0;
        advance();
        checks++;
        if (ifc.state_o !== 2'd2 || ifc.siren !== 3'b000 || ifc.armed_led !== 1'b1) begin
            errors++;
            $display("FAIL alarm_exit: got state=%0d siren=%b led=%b, want state=2 siren=000 led=1",
                     ifc.state_o, ifc.siren, ifc.armed_led);
        end
    endtask

    task automatic test_simultaneous();
        ifc.set_in = 1'b0;
        repeat (3) advance();
        checks++;
        if (ifc.state_o !== 2'd0) begin
            errors++;
            $display("FAIL disarm: got state=%0d, want 0", ifc.state_o);
        end
        ifc.set_in   = 1'b1;
        ifc.alarm_in = 1'b1;
        advance();
        checks++;
        if (ifc.state_o !== 2'd3 || ifc.siren !== 3'b100) begin
            errors++;
            $display("FAIL same_cycle: got state=%0d siren=%b, want state=3 siren=100",
                     ifc.state_o, ifc.siren);
        end
        for (int i = 1; i <= 8; i++) begin
            advance();
            checks++;
            if (ifc.state_o !== 2'd3) begin
                errors++;
                $display("FAIL no_chirp[%0d]: got state=%0d, want 3", i, ifc.state_o);
            end
        end
        checks++;
        if (ifc.siren !== 3'b001) begin
            errors++;
            $display("FAIL blue_phase: got siren=%b, want 001", ifc.siren);
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({ifc.siren, ifc.armed_led, ifc.state_o} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset: got siren=%b led=%b state=%0d, want all 0",
                     ifc.siren, ifc.armed_led, ifc.state_o);
        end
        @(negedge clock);
        reset = 1'b0;
        advance();
        checks++;
        if (ifc.state_o !== 2'd3 || ifc.siren !== 3'b100) begin
            errors++;
            $display("FAIL reset_resume: got state=%0d siren=%b, want state=3 siren=100",
                     ifc.state_o, ifc.siren);
        end
    endtask

    task automatic test_random();
        int dur;
        for (int seg = 0; seg < 60; seg++) begin
            if ($urandom_range(0, 9) == 0) begin
                reset = 1'b1;
                model_reset();
                @(negedge clock);
                reset = 1'b0;
            end
            ifc.set_in   = ($urandom_range(0, 2) != 0);
            ifc.alarm_in = ($urandom_range(0, 4) == 0);
            dur = $urandom_range(1, 30);
            for (int c = 0; c < dur; c++) begin
                advance();
                checks++;
                if (ifc.state_o !== 2'(m_state) || ifc.siren !== m_siren || ifc.armed_led !== m_led) begin
                    errors++;
                    $display("FAIL random[%0d.%0d]: got state=%0d siren=%b led=%b, want state=%0d siren=%b led=%b",
                             seg, c, ifc.state_o, ifc.siren, ifc.armed_led, m_state, m_siren, m_led);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_arming();
        test_alarm_pattern();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/siren_sequencer.md
Name: siren_sequencer

Overview:
- Downstream output stage of the alarm controller; consumes its `set` (armed) and siren-active levels.
- Drives the 3-bit RGB "siren" LED with a timed strobe pattern, an arming chirp and an armed heartbeat LED.
- Contains its own clock prescaler, so the controller only supplies steady levels.
- Inputs are synchronous to `clock` (already debounced/registered upstream).

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz.
- STEP_HZ, 4, pattern step rate in Hz; DIV = CLK_HZ/STEP_HZ clock cycles per step (integer, >= 2).
- CHIRP_COUNT, 2, number of white flashes emitted on arming (1..7).

Ports:
- clock  in  1  system clock (rising edge).
- reset  in  1  asynchronous, active-high.
- set_in  in  1  armed level from the alarm controller.
- alarm_in  in  1  siren-active level from the alarm controller.
- siren  out  3  RGB drive {R,G,B}, registered.
- armed_led  out  1  heartbeat LED, registered.
- state_o  out  2  current state, for display/debug.

Behaviour:
- Reset values: siren=0, armed_led=0, state_o=IDLE, prescaler=0, step index=0, set_in edge register=0.
- States: IDLE=0, CHIRP=1, ARMED=2, ALARM=3. All outputs are registered and change on the same edge as the state.
- Prescaler:
  - Counts 0..DIV-1 in any non-IDLE state and emits a 1-cycle step pulse at DIV-1.
  - Held at 0 in IDLE.
  - Cleared to 0 on every state change, so the first step of any state occurs exactly DIV cycles after entry.
- Step index: 3 bits, cleared on every state change, incremented on each step pulse, wraps 7->0.
- Rising edge of set_in: detected by comparing set_in with a registered copy.
- Transitions, evaluated every cycle, priority top-down:
  1. alarm_in=1 -> ALARM, from any state. Staying in ALARM does not restart its pattern.
  2. In ALARM with alarm_in=0 -> ARMED if set_in=1, else IDLE.
  3. set_in=0 in CHIRP or ARMED -> IDLE.
  4. IDLE with a set_in rising edge -> CHIRP.
  5. CHIRP after 2*CHIRP_COUNT step pulses -> ARMED. The exiting step pulse and the state change occur on the same edge.
- Latency: an input change sampled at edge N is reflected in state_o, siren and armed_led at edge N+1.
- Outputs per state:
  - IDLE: siren=000, armed_led=0.
  - CHIRP: siren=111 while step index is even, 000 while odd; armed_led=0.
  - ARMED: siren=000; armed_led=1 only while step index=0, i.e. on for DIV cycles of every 8*DIV.
  - ALARM: step index[1:0] selects RED 100, off 000, BLUE 001, off 000, repeating; armed_led=0.
- Boundary cases:
  - alarm_in rising in the same cycle as a set_in edge: ALARM wins; the edge is discarded.
  - set_in already high when leaving ALARM: goes to ARMED with no chirp.
  - Reset asserted mid-pattern: immediately forces the reset values; no partial step is resumed.

Optional Feature:
- Macro SIREN_CHIRP_EN.
- Defined: CHIRP state and chirp logic are present as described above.
- Undefined:
  - CHIRP logic is compiled out; a set_in rising edge in IDLE goes directly to ARMED.
  - state_o never shows 1.
  - CHIRP_COUNT is ignored.

Test Plan (CLK_HZ=8, STEP_HZ=2, so DIV=4; CHIRP_COUNT=2; SIREN_CHIRP_EN defined unless noted):
- Reset held, then released with inputs low -> siren=000, armed_led=0, state_o=0 for 20 cycles.
- set_in rises at edge N, held high:
  - state_o=1 and siren=111 from N+1 through N+4, then 000 for 4 cycles, 111 for 4, 000 for 4.
  - At N+17: state_o=2 and armed_led=1 for 4 cycles, then 0 for 28 cycles, then repeats.
- In ARMED, alarm_in rises at edge M:
  - From M+1: siren sequence 100 x4, 000 x4, 001 x4, 000 x4, repeating over 3 periods; armed_led=0.
  - alarm_in falls -> next edge state_o=2, armed_led=1, siren=000.
- alarm_in and set_in rise in the same cycle -> next edge state_o=3 and siren=100; the CHIRP state is never visited.
- Reset pulsed while in ALARM with siren=001 -> outputs 0 immediately (asynchronously).
  - After release with alarm_in still high: state_o=3 one edge later, with RED shown first.
- SIREN_CHIRP_EN undefined, set_in rises at N -> at N+1 state_o=2, armed_led=1, siren=000.
